// File: rtl/hazard_forwarding_unit_mc_pkg.sv
// Shared definitions for the ID-stage hazard/forwarding unit:
// forwarding select codes, load-stall FSM states and counter widths.
package hazard_forwarding_unit_mc_pkg;

    // Operand source select codes
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    // Load-stall counter covers LOAD_LAT up to 7, MDU counter MDU_LAT up to 63
    localparam int LD_CNT_W  = 3;
    localparam int MDU_CNT_W = 6;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_e;

    // Only a clean 1 counts as an active write enable; X/Z reads as 0
    function automatic logic is_one(input logic b);
        return (b === 1'b1);
    endfunction

endpackage

// File: rtl/hazard_forwarding_unit_mc_fwd_select.sv
// Single-operand forwarding mux: picks the youngest in-flight producer
// (EX > MEM > WB) of the requested register, never forwarding $zero.
module hazard_forwarding_unit_mc_fwd_select
    import hazard_forwarding_unit_mc_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             use_i,
    input  logic [REG_W-1:0] operand_i,
    input  logic             en_ex_i,
    input  logic [REG_W-1:0] reg_ex_i,
    input  logic             en_mem_i,
    input  logic [REG_W-1:0] reg_mem_i,
    input  logic             en_wb_i,
    input  logic [REG_W-1:0] reg_wb_i,
    output logic [1:0]       fwd_o
);

    // Priority select from the most recent stage that writes this register
    always_comb begin
        // NOTE: default assignment first so no path through the block leaves fwd_o unassigned (no latch).
        fwd_o = FWD_RF;
        if (use_i && (operand_i != '0)) begin
            if (en_ex_i && (reg_ex_i == operand_i)) begin
                fwd_o = FWD_EX;
            end else if (en_mem_i && (reg_mem_i == operand_i)) begin
                fwd_o = FWD_MEM;
            end else if (en_wb_i && (reg_wb_i == operand_i)) begin
                fwd_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_forwarding_unit_mc.sv
// ID-stage hazard unit: operand forwarding, multi-cycle load-use stall
// sequencing, HI/LO busy stall for the MDU, branch flush and a saturating
// count of stalled cycles.
module hazard_forwarding_unit_mc
    import hazard_forwarding_unit_mc_pkg::*;
#(
    parameter int REG_W       = 5,
    parameter int LOAD_LAT    = 1,
    parameter int MDU_LAT     = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enableEX,
    input  logic                   enableMEM,
    input  logic                   enableWB,
    input  logic                   loadEX,
    input  logic [REG_W-1:0]       regEX,
    input  logic [REG_W-1:0]       regMEM,
    input  logic [REG_W-1:0]       regWB,
    input  logic [REG_W-1:0]       operandA,
    input  logic [REG_W-1:0]       operandB,
    input  logic                   useA,
    input  logic                   useB,
    input  logic                   useHiLoID,
    input  logic                   mduStartEX,
    input  logic                   branchTakenID,
    output logic [1:0]             fwdA,
    output logic [1:0]             fwdB,
    output logic                   stallPC,
    output logic                   stallNPC,
    output logic                   stallIFID,
    output logic                   controlMux,
    output logic                   flushIFID,
    output logic                   hiloBusy,
    output logic [STALL_CNT_W-1:0] stallCount
);

    logic                   en_ex;
    logic                   en_mem;
    logic                   en_wb;
    logic                   haz_load;
    logic                   haz_mdu;
    logic                   stall;
    state_e                 state_q;
    logic [LD_CNT_W-1:0]    ld_cnt_q;
    logic [MDU_CNT_W-1:0]   mdu_cnt_q;
    logic [MDU_CNT_W-1:0]   mdu_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d;

    assign en_ex  = is_one(enableEX);
    assign en_mem = is_one(enableMEM);
    assign en_wb  = is_one(enableWB);

    hazard_forwarding_unit_mc_fwd_select #(.REG_W(REG_W)) u_fwd_a (
        .use_i     (useA),
        .operand_i (operandA),
        .en_ex_i   (en_ex),
        .reg_ex_i  (regEX),
        .en_mem_i  (en_mem),
        .reg_mem_i (regMEM),
        .en_wb_i   (en_wb),
        .reg_wb_i  (regWB),
        .fwd_o     (fwdA)
    );

    hazard_forwarding_unit_mc_fwd_select #(.REG_W(REG_W)) u_fwd_b (
        .use_i     (useB),
        .operand_i (operandB),
        .en_ex_i   (en_ex),
        .reg_ex_i  (regEX),
        .en_mem_i  (en_mem),
        .reg_mem_i (regMEM),
        .en_wb_i   (en_wb),
        .reg_wb_i  (regWB),
        .fwd_o     (fwdB)
    );

    // A load in EX cannot forward its data to ID yet; any real read of its target must wait
    assign haz_load = loadEX & en_ex & (regEX != '0) &
                      ((useA & (operandA == regEX)) | (useB & (operandB == regEX)));

    assign hiloBusy = (mdu_cnt_q != '0);
    assign haz_mdu  = useHiLoID & hiloBusy;

    // First load-stall cycle is combinational; later ones come from LOAD_WAIT
    assign stall = (haz_load & (state_q == IDLE)) | (state_q != IDLE) | haz_mdu;

    assign stallPC    = ~stall;
    assign stallNPC   = ~stall;
    assign stallIFID  = ~stall;
    assign controlMux = stall;
    // Branch operands are stale while stalled, so a taken branch cannot flush yet
    assign flushIFID  = branchTakenID & ~stall;
    assign stallCount = stall_cnt_q;

    // Load-use stall sequencer: holds the stall for the remaining LOAD_LAT-1 cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ld_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (state_q)
                IDLE: begin
                    if (haz_load && (LOAD_LAT > 1)) begin
                        state_q  <= LOAD_WAIT;
                        ld_cnt_q <= LD_CNT_W'(LOAD_LAT - 1);
                    end
                end
                LOAD_WAIT: begin
                    if (ld_cnt_q == LD_CNT_W'(1)) begin
                        state_q <= IDLE;
                    end
                    ld_cnt_q <= ld_cnt_q - LD_CNT_W'(1);
                end
                default: begin
                    state_q  <= IDLE;
                    ld_cnt_q <= '0;
                end
            endcase
        end
    end

    // MDU busy countdown: a new start always restarts the full latency
    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (mduStartEX) begin
            mdu_cnt_d = MDU_CNT_W'(MDU_LAT);
        end else if (mdu_cnt_q != '0) begin
            mdu_cnt_d = mdu_cnt_q - MDU_CNT_W'(1);
        end
    end

    // Stall counter next value, sticking at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mdu_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            mdu_cnt_q   <= mdu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_forwarding_unit_mc.sv
// Scoreboard bench for hazard_forwarding_unit_mc. Two instances share the
// stimulus: one with LOAD_LAT=1 and a 16-bit stall counter, one with
// LOAD_LAT=3 and a 5-bit stall counter. The driver computes the expected
// outputs from a cycle-indexed model (stall windows and busy deadlines)
// and queues them; a negedge monitor pops and compares.
module tb_hazard_forwarding_unit_mc;

    localparam int REG_W   = 5;
    localparam int MDU_LAT = 4;
    localparam int LAT [2] = '{1, 3};
    localparam int SAT [2] = '{65535, 31};

    logic             clk = 1'b0;
    logic             reset;
    logic             enableEX, enableMEM, enableWB, loadEX;
    logic [REG_W-1:0] regEX, regMEM, regWB, operandA, operandB;
    logic             useA, useB, useHiLoID, mduStartEX, branchTakenID;

    logic [1:0]  fwdA1, fwdB1, fwdA3, fwdB3;
    logic        stallPC1, stallNPC1, stallIFID1, controlMux1, flushIFID1, hiloBusy1;
    logic        stallPC3, stallNPC3, stallIFID3, controlMux3, flushIFID3, hiloBusy3;
    logic [15:0] stallCount1;
    logic [4:0]  stallCount3;

    always #5 clk = ~clk;

    hazard_forwarding_unit_mc #(.REG_W(REG_W), .LOAD_LAT(1), .MDU_LAT(MDU_LAT), .STALL_CNT_W(16)) u_dut1 (
        .clk(clk), .reset(reset), .enableEX(enableEX), .enableMEM(enableMEM), .enableWB(enableWB),
        .loadEX(loadEX), .regEX(regEX), .regMEM(regMEM), .regWB(regWB),
        .operandA(operandA), .operandB(operandB), .useA(useA), .useB(useB),
        .useHiLoID(useHiLoID), .mduStartEX(mduStartEX), .branchTakenID(branchTakenID),
        .fwdA(fwdA1), .fwdB(fwdB1), .stallPC(stallPC1), .stallNPC(stallNPC1),
        .stallIFID(stallIFID1), .controlMux(controlMux1), .flushIFID(flushIFID1),
        .hiloBusy(hiloBusy1), .stallCount(stallCount1)
    );

    hazard_forwarding_unit_mc #(.REG_W(REG_W), .LOAD_LAT(3), .MDU_LAT(MDU_LAT), .STALL_CNT_W(5)) u_dut3 (
        .clk(clk), .reset(reset), .enableEX(enableEX), .enableMEM(enableMEM), .enableWB(enableWB),
        .loadEX(loadEX), .regEX(regEX), .regMEM(regMEM), .regWB(regWB),
        .operandA(operandA), .operandB(operandB), .useA(useA), .useB(useB),
        .useHiLoID(useHiLoID), .mduStartEX(mduStartEX), .branchTakenID(branchTakenID),
        .fwdA(fwdA3), .fwdB(fwdB3), .stallPC(stallPC3), .stallNPC(stallNPC3),
        .stallIFID(stallIFID3), .controlMux(controlMux3), .flushIFID(flushIFID3),
        .hiloBusy(hiloBusy3), .stallCount(stallCount3)
    );

    typedef struct {
        string      tag;
        int         cyc;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       st1;
        logic       st3;
        logic       fl1;
        logic       fl3;
        logic       hilo;
        int         sc1;
        int         sc3;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: cycle index, end of each instance's load-stall window,
    // end of the HI/LO busy window, and raw stall-cycle tallies.
    int cyc = 0;
    int load_end [2] = '{0, 0};
    int busy_end = 0;
    int scount [2] = '{0, 0};

    task automatic check(input string name, input int cyc_n, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d", name, cyc_n, act, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic u, input logic [REG_W-1:0] op);
        if (!u || op == 0) return 2'b00;
        if (enableEX === 1'b1 && regEX == op) return 2'b01;
        if (enableMEM === 1'b1 && regMEM == op) return 2'b10;
        if (enableWB === 1'b1 && regWB == op) return 2'b11;
        return 2'b00;
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    // Inputs are already applied (just after a posedge); queue the expectation, then advance the model
    task automatic step(input string tag);
        exp_t e;
        logic hazl, hazm, hilo;
        logic st [2];
        hilo = !reset && (cyc < busy_end);
        hazl = loadEX && (enableEX === 1'b1) && (regEX != 0) &&
               ((useA && operandA == regEX) || (useB && operandB == regEX));
        hazm = useHiLoID && hilo;
        for (int d = 0; d < 2; d++) st[d] = (!reset && cyc < load_end[d]) || hazl || hazm;
        e.tag  = tag;
        e.cyc  = cyc;
        e.fa   = ref_fwd(useA, operandA);
        e.fb   = ref_fwd(useB, operandB);
        e.st1  = st[0];
        e.st3  = st[1];
        e.fl1  = branchTakenID && !st[0];
        e.fl3  = branchTakenID && !st[1];
        e.hilo = hilo;
        e.sc1  = reset ? 0 : sat(scount[0], SAT[0]);
        e.sc3  = reset ? 0 : sat(scount[1], SAT[1]);
        sb_q.push_back(e);
        @(posedge clk);
        if (reset) begin
            load_end = '{0, 0};
            busy_end = 0;
            scount   = '{0, 0};
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (st[d]) scount[d]++;
                if (!(cyc < load_end[d]) && hazl) load_end[d] = cyc + LAT[d];
            end
            if (mduStartEX) busy_end = cyc + 1 + MDU_LAT;
        end
        cyc++;
        #1;
    endtask

    task automatic quiet();
        enableEX = 0; enableMEM = 0; enableWB = 0; loadEX = 0;
        regEX = 0; regMEM = 0; regWB = 0; operandA = 0; operandB = 0;
        useA = 0; useB = 0; useHiLoID = 0; mduStartEX = 0; branchTakenID = 0;
    endtask

    // Monitor: outputs are stable mid-cycle
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.tag, ":fwdA1"}, e.cyc, fwdA1, e.fa);
            check({e.tag, ":fwdB1"}, e.cyc, fwdB1, e.fb);
            check({e.tag, ":fwdA3"}, e.cyc, fwdA3, e.fa);
            check({e.tag, ":fwdB3"}, e.cyc, fwdB3, e.fb);
            check({e.tag, ":stall1"}, e.cyc, {stallPC1, stallNPC1, stallIFID1, controlMux1},
                  e.st1 ? 4'b0001 : 4'b1110);
            check({e.tag, ":stall3"}, e.cyc, {stallPC3, stallNPC3, stallIFID3, controlMux3},
                  e.st3 ? 4'b0001 : 4'b1110);
            check({e.tag, ":flush1"}, e.cyc, flushIFID1, e.fl1);
            check({e.tag, ":flush3"}, e.cyc, flushIFID3, e.fl3);
            check({e.tag, ":hilo1"}, e.cyc, hiloBusy1, e.hilo);
            check({e.tag, ":hilo3"}, e.cyc, hiloBusy3, e.hilo);
            check({e.tag, ":scnt1"}, e.cyc, stallCount1, e.sc1);
            check({e.tag, ":scnt3"}, e.cyc, stallCount3, e.sc3);
        end
    end

    initial begin
        quiet();
        reset = 1;
        @(posedge clk);
        #1;
        step("reset");
        step("reset");
        reset = 0;
        step("idle");

        // Forwarding priority
        enableMEM = 1; regMEM = 8; operandA = 8; useA = 1; enableEX = 1; regEX = 8;
        step("fwd_ex");
        enableEX = 0;
        step("fwd_mem");
        regEX = 0; regMEM = 0; regWB = 0; operandA = 0; enableEX = 1; enableWB = 1;
        step("fwd_zero");
        quiet();
        step("idle");

        // Load-use hazard on B, with a taken branch arriving during the stall
        loadEX = 1; enableEX = 1; regEX = 9; operandB = 9; useB = 1;
        step("load");
        loadEX = 0; branchTakenID = 1;
        for (int i = 0; i < 4; i++) step("load_after");
        branchTakenID = 0;

        // Same hazard, but B not actually read
        loadEX = 1; useB = 0;
        step("load_nouse");
        quiet();
        step("idle");

        // MDU busy stall for a HI/LO reader
        mduStartEX = 1;
        step("mdu_start");
        mduStartEX = 0; useHiLoID = 1;
        for (int i = 0; i < 6; i++) step("mdu_wait");
        quiet();
        branchTakenID = 1;
        step("branch");
        quiet();

        // Reset while in LOAD_WAIT with the MDU busy
        loadEX = 1; enableEX = 1; regEX = 9; operandB = 9; useB = 1; mduStartEX = 1;
        step("pre_reset");
        loadEX = 0; mduStartEX = 0; useHiLoID = 1;
        step("pre_reset2");
        reset = 1;
        step("reset_mid");
        reset = 0;
        step("post_reset");
        quiet();
        step("idle");

        // Randomised traffic; small register range makes matches common
        for (int i = 0; i < 400; i++) begin
            enableEX      = 1'($urandom_range(0, 1));
            enableMEM     = 1'($urandom_range(0, 1));
            enableWB      = 1'($urandom_range(0, 1));
            loadEX        = ($urandom_range(0, 3) == 0);
            regEX         = REG_W'($urandom_range(0, 3));
            regMEM        = REG_W'($urandom_range(0, 3));
            regWB         = REG_W'($urandom_range(0, 3));
            operandA      = REG_W'($urandom_range(0, 3));
            operandB      = REG_W'($urandom_range(0, 3));
            useA          = 1'($urandom_range(0, 1));
            useB          = 1'($urandom_range(0, 1));
            useHiLoID     = ($urandom_range(0, 2) == 0);
            mduStartEX    = ($urandom_range(0, 7) == 0);
            branchTakenID = 1'($urandom_range(0, 1));
            step("rand");
        end
        quiet();

        // Counter saturation: keep the MDU busy with a HI/LO reader waiting
        mduStartEX = 1; useHiLoID = 1;
        for (int i = 0; i < 65545; i++) step("sat");
        mduStartEX = 0;
        for (int i = 0; i < 6; i++) step("sat_drain");
        quiet();
        step("final");

        for (int k = 0; k < 4 && sb_q.size() != 0; k++) @(negedge clk);
        #1;
        check("sb_drain", cyc, sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
